// File: rtl/vga_scan_out.sv
// VGA 640x480 scan-out: raster timing, pixel request pacing, color FIFO and
// registered DAC outputs. Raster counters stay frozen until the FIFO is primed.
//
// state | meaning
// PRIME | counters held at 0, requests fill the FIFO
// RUN   | raster running, pops on visible pixel enables
module vga_scan_out #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] color,
    output logic        VGA_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        underflow
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int N_PIX   = H_VIS * V_VIS;
    localparam int DW      = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int RW      = $clog2(N_PIX + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

    typedef enum logic {PRIME, RUN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [RW-1:0]   req_cnt_q, req_cnt_d;
    logic            ready_q, ready_d;
    logic            cap_q, cap_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [23:0]     rgb_q, rgb_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            blank_n_q, blank_n_d;
    logic            underflow_q, underflow_d;
    logic [23:0]     mem_q [FIFO_DEPTH];

    logic            pe;
    logic            vis;
    logic            push;
    logic            pop;
    logic [CW:0]     fill_sum;

    // Response arrives one cycle after the request.
    assign push = cap_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        h_d         = h_q;
        v_d         = v_q;
        req_cnt_d   = req_cnt_q + {{(RW-1){1'b0}}, ready_q};
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rgb_d       = rgb_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        blank_n_d   = blank_n_q;
        underflow_d = underflow_q;
        cap_d       = ready_q;

        pe  = (state_q == RUN) && (div_q == DIV_LAST);
        vis = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
        pop = pe && vis && (cnt_q != '0);

        if (state_q == PRIME && cnt_q == CW'(FIFO_DEPTH)) begin
            state_d = RUN;
        end

        if (state_q == RUN) begin
            div_d = pe ? '0 : div_q + 1'b1;
            if (pe) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end

        // Rewind at the start of vertical blank so the next frame prefetches early.
        if (pe && h_q == '0 && v_q == VW'(V_VIS)) begin
            req_cnt_d = '0;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        fill_sum = {1'b0, cnt_d} + {{CW{1'b0}}, ready_q};
        ready_d  = (fill_sum < (CW+1)'(FIFO_DEPTH)) && (req_cnt_d < RW'(N_PIX));

        if (pe) begin
            rgb_d     = pop ? mem_q[rd_ptr_q] : 24'd0;
            blank_n_d = vis;
            hsync_d   = !(h_q >= HS_START && h_q < HS_END);
            vsync_d   = !(v_q >= VS_START && v_q < VS_END);
            if (vis && cnt_q == '0) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            req_cnt_q   <= '0;
            ready_q     <= 1'b0;
            cap_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            blank_n_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            req_cnt_q   <= req_cnt_d;
            ready_q     <= ready_d;
            cap_q       <= cap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_n_q   <= blank_n_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= color;
    end

    assign VGA_ready   = ready_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign underflow   = underflow_q;
endmodule
